// File: rtl/pfb_snapshot_ctrl.sv
// Capture sequencer for the PFB output snapshot RAM (fabric-side port A).
// Arm, wait for trigger, write len+1 consecutive valid words from address 0, then flag done.
module pfb_snapshot_ctrl #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_arm,
  input  logic              i_use_trig,
  input  logic              i_trig,
  input  logic [AWIDTH-1:0] i_len_m1,
  input  logic [DWIDTH-1:0] i_din,
  input  logic              i_din_valid,
  output logic              o_bram_we,
  output logic              o_bram_en_a,
  output logic [AWIDTH-1:0] o_bram_addr,
  output logic [DWIDTH-1:0] o_bram_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [AWIDTH:0]   o_wr_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_arm_d;
  logic              r_trig_latch;
  logic [AWIDTH-1:0] r_len;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;
  logic              r_busy;
  logic              r_done;
  logic [AWIDTH:0]   r_wr_count;

  logic w_arm_edge;
  logic w_trig_hit;
  logic w_last;

  assign w_arm_edge = i_arm & ~r_arm_d;
  assign w_trig_hit = i_trig | r_trig_latch | ~i_use_trig;
  // In CAPTURE the word being written lands at r_wr_count; it is the last one when that equals len.
  assign w_last     = (r_wr_count == {1'b0, r_len});

  // Arm history is a plain delay so a level held high across reset is seen only once.
  always_ff @(posedge i_clk) begin
    r_arm_d <= i_arm;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_trig_latch <= 1'b0;
      r_len        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_arm_edge) begin
            r_state      <= S_ARMED;
            r_len        <= i_len_m1;
            r_wr_count   <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_trig_latch <= 1'b0;
          end
        end
        S_ARMED: begin
          if (i_trig && !i_din_valid)
            r_trig_latch <= 1'b1;
          if (w_trig_hit && i_din_valid) begin
            r_we       <= 1'b1;
            r_addr     <= '0;
            r_data     <= i_din;
            r_wr_count <= (AWIDTH+1)'(1);
            if (r_len == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (i_din_valid) begin
            r_we       <= 1'b1;
            r_addr     <= r_wr_count[AWIDTH-1:0];
            r_data     <= i_din;
            r_wr_count <= r_wr_count + (AWIDTH+1)'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bram_we      = r_we;
  assign o_bram_en_a    = r_we;
  assign o_bram_addr    = r_addr;
  assign o_bram_wr_data = r_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_wr_count     = r_wr_count;

endmodule
